// File: rtl/lc3_imem_fetch_pkg.sv
// Shared types and constants for the LC-3 instruction-memory fetch responder.
package lc3_imem_fetch_pkg;

  localparam int unsigned MAX_WAIT_STATES = 3;
  localparam int unsigned ERR_COUNT_W     = 8;
  localparam int unsigned INSTR_W         = 16;
  localparam int unsigned WAIT_CNT_W      = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } fetch_state_e;

endpackage

// File: rtl/lc3_imem_array.sv
// Synchronous-read, single-write instruction array. Storage is never reset so
// preloaded code survives a core reset.
module lc3_imem_array
  import lc3_imem_fetch_pkg::*;
#(
  parameter int unsigned MEM_AW = 8
) (
  input  logic               clock,
  input  logic               rd_en,
  input  logic [MEM_AW-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [MEM_AW-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data
);

  localparam int unsigned Depth = 1 << MEM_AW;

  logic [INSTR_W-1:0] mem [Depth];

  // Read and write on the same edge to the same word return the old contents.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/lc3_imem_fetch_responder.sv
// Instruction fetch responder: accepts fetches, waits WAIT_STATES cycles, returns one word.
// Optional protocol checker enabled by defining LC3_IMEM_FETCH_PROTOCOL_CHECK_EN.
module lc3_imem_fetch_responder
  import lc3_imem_fetch_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MEM_AW      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INSTR_W-1:0]     npc,
  input  logic [INSTR_W-1:0]     pc,
  input  logic                   instrmem_rd,
  input  logic                   load_en,
  input  logic [MEM_AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0]     load_data,
  output logic [INSTR_W-1:0]     instr_dout,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     npc_dout,
  output logic                   busy,
  output logic                   proto_err,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam logic [WAIT_CNT_W-1:0] WaitLoad =
      (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  fetch_state_e          state_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [INSTR_W-1:0]    npc_cap_q;
  logic [INSTR_W-1:0]    instr_hold_q;
  logic [INSTR_W-1:0]    npc_hold_q;
  logic [INSTR_W-1:0]    rd_data;
  logic                  accept;

  assign accept = instrmem_rd && ((state_q == StIdle) || (state_q == StResp));

  lc3_imem_array #(
    .MEM_AW(MEM_AW)
  ) u_array (
    .clock   (clock),
    .rd_en   (accept),
    .rd_addr (pc[MEM_AW-1:0]),
    .rd_data (rd_data),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      npc_cap_q    <= '0;
      instr_hold_q <= '0;
      npc_hold_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StResp: begin
          if (accept) begin
            state_q    <= (WAIT_STATES == 0) ? StResp : StWait;
            wait_cnt_q <= WaitLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (wait_cnt_q == '0) begin
            state_q <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (accept) begin
        npc_cap_q <= npc;
      end
      // Snapshot the presented response so outputs hold once RESP is left.
      if (state_q == StResp) begin
        instr_hold_q <= rd_data;
        npc_hold_q   <= npc_cap_q;
      end
    end
  end

  assign instr_valid = (state_q == StResp);
  assign busy        = (state_q == StWait);
  assign instr_dout  = instr_valid ? rd_data : instr_hold_q;
  assign npc_dout    = instr_valid ? npc_cap_q : npc_hold_q;

  // Fetch addresses wrap: bits above the array width are deliberately dropped.
  if (MEM_AW < INSTR_W) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^pc[INSTR_W-1:MEM_AW];
  end

`ifdef LC3_IMEM_FETCH_PROTOCOL_CHECK_EN
  logic                   overrun;
  logic                   npc_bad;
  logic                   proto_err_q;
  logic [ERR_COUNT_W-1:0] err_count_q;

  assign overrun = instrmem_rd && (state_q == StWait);
  assign npc_bad = accept && (npc != INSTR_W'(pc + 16'd1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      proto_err_q <= 1'b0;
      err_count_q <= '0;
    end else if (overrun || npc_bad) begin
      proto_err_q <= 1'b1;
      if (err_count_q != '1) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign proto_err = proto_err_q;
  assign err_count = err_count_q;
`else
  assign proto_err = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_lc3_imem_fetch_responder.sv
// Scoreboard bench for lc3_imem_fetch_responder with WAIT_STATES of 0, 1 and 3.
module tb_lc3_imem_fetch_responder;

`ifdef LC3_IMEM_FETCH_PROTOCOL_CHECK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] pc    [3];
  logic [15:0] npc   [3];
  logic        rd    [3];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] dout  [3];
  logic        valid [3];
  logic [15:0] npco  [3];
  logic        busy  [3];
  logic        perr  [3];
  logic [7:0]  ecnt  [3];

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  int pass_n  = 0;
  int total_n = 0;
  int busy_n;
  int valid_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lc3_imem_fetch_responder #(.WAIT_STATES(0), .MEM_AW(8)) u_dut0 (
    .clock(clk), .reset(reset), .npc(npc[0]), .pc(pc[0]), .instrmem_rd(rd[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr_dout(dout[0]), .instr_valid(valid[0]), .npc_dout(npco[0]), .busy(busy[0]),
    .proto_err(perr[0]), .err_count(ecnt[0])
  );

  lc3_imem_fetch_responder #(.WAIT_STATES(1), .MEM_AW(8)) u_dut1 (
    .clock(clk), .reset(reset), .npc(npc[1]), .pc(pc[1]), .instrmem_rd(rd[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr_dout(dout[1]), .instr_valid(valid[1]), .npc_dout(npco[1]), .busy(busy[1]),
    .proto_err(perr[1]), .err_count(ecnt[1])
  );

  lc3_imem_fetch_responder #(.WAIT_STATES(3), .MEM_AW(8)) u_dut3 (
    .clock(clk), .reset(reset), .npc(npc[2]), .pc(pc[2]), .instrmem_rd(rd[2]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instr_dout(dout[2]), .instr_valid(valid[2]), .npc_dout(npco[2]), .busy(busy[2]),
    .proto_err(perr[2]), .err_count(ecnt[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic push_exp(input int k, input logic [15:0] d, input logic [15:0] n);
    case (k)
      0:       q0.push_back({d, n});
      1:       q1.push_back({d, n});
      default: q2.push_back({d, n});
    endcase
  endtask

  task automatic check_resp(input int k);
    logic [31:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (have) begin
      chk($sformatf("resp_dut%0d", k), {dout[k], npco[k]}, e);
    end else begin
      total_n++;
      $display("FAIL unexpected_resp_dut%0d: got %h/%h, required no response", k, dout[k],
               npco[k]);
    end
  endtask

  // Monitor: every response strobe is matched against the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (valid[k] === 1'b1) check_resp(k);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input int k, input logic [15:0] p, input logic [15:0] n, input logic r);
    pc[k]  = p;
    npc[k] = n;
    rd[k]  = r;
  endtask

  logic [7:0]  pre_addr [8];
  logic [15:0] pre_data [8];

  initial begin
    pre_addr = '{8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h20, 8'h40};
    pre_data = '{16'h1234, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'h0505, 16'h2020,
                 16'h4444};
    reset     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int k = 0; k < 3; k++) drive(k, 16'h0, 16'h0, 1'b0);

    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_dout%0d", k), 32'(dout[k]), 32'h0);
      chk($sformatf("rst_valid%0d", k), 32'(valid[k]), 32'h0);
      chk($sformatf("rst_npc%0d", k), 32'(npco[k]), 32'h0);
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'h0);
      chk($sformatf("rst_perr%0d", k), 32'(perr[k]), 32'h0);
      chk($sformatf("rst_ecnt%0d", k), 32'(ecnt[k]), 32'h0);
    end
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step();
      load_en   = 1'b1;
      load_addr = pre_addr[i];
      load_data = pre_data[i];
    end
    step();
    load_en = 1'b0;

    // Single fetch, one wait state: response two edges after acceptance.
    step(); drive(1, 16'h0010, 16'h0011, 1'b1); push_exp(1, 16'h1234, 16'h0011);
    step(); rd[1] = 1'b0;
    chk("ws1_valid_early", 32'(valid[1]), 32'h0);
    chk("ws1_busy", 32'(busy[1]), 32'h1);
    step(); chk("ws1_valid_on_time", 32'(valid[1]), 32'h1);
    step(); chk("ws1_valid_drop", 32'(valid[1]), 32'h0);
    chk("ws1_dout_hold", 32'(dout[1]), 32'h1234);
    chk("ws1_npc_hold", 32'(npco[1]), 32'h0011);

    // Zero wait states, streaming four fetches back-to-back.
    for (int i = 0; i < 4; i++) begin
      step();
      drive(0, 16'h3000 + 16'(i), 16'h3001 + 16'(i), 1'b1);
      push_exp(0, 16'hA000 + 16'(i), 16'h3001 + 16'(i));
      if (i > 0) chk($sformatf("ws0_stream_valid%0d", i - 1), 32'(valid[0]), 32'h1);
    end
    step(); rd[0] = 1'b0; chk("ws0_stream_valid3", 32'(valid[0]), 32'h1);
    step(); chk("ws0_stream_end", 32'(valid[0]), 32'h0);

    // Load and fetch of the same word on one edge returns the old word.
    step();
    load_en = 1'b1; load_addr = 8'h40; load_data = 16'h5555;
    drive(0, 16'h0040, 16'h0041, 1'b1); push_exp(0, 16'h4444, 16'h0041);
    step(); load_en = 1'b0; push_exp(0, 16'h5555, 16'h0041);
    step(); rd[0] = 1'b0;
    step();
    step();

    // Three wait states with an overrun request during WAIT.
    step(); drive(2, 16'h0010, 16'h0011, 1'b1); push_exp(2, 16'h1234, 16'h0011);
    busy_n = 0; valid_n = 0;
    step(); drive(2, 16'h0005, 16'h0006, 1'b1);
    busy_n += int'(busy[2]); valid_n += int'(valid[2]);
    step(); rd[2] = 1'b0;
    busy_n += int'(busy[2]); valid_n += int'(valid[2]);
    for (int i = 0; i < 4; i++) begin
      step();
      busy_n += int'(busy[2]); valid_n += int'(valid[2]);
    end
    chk("ws3_busy_cycles", 32'(busy_n), 32'd3);
    chk("ws3_valid_cycles", 32'(valid_n), 32'd1);
    chk("ws3_err_count", 32'(ecnt[2]), Chk ? 32'd1 : 32'd0);
    chk("ws3_proto_err", 32'(perr[2]), 32'(Chk));

    // Upper pc bits are dropped.
    step(); drive(1, 16'h1105, 16'h1106, 1'b1); push_exp(1, 16'h0505, 16'h1106);
    step(); rd[1] = 1'b0;
    step();
    step(); chk("wrap_dout_hold", 32'(dout[1]), 32'h0505);
    chk("wrap_no_err", 32'(ecnt[1]), 32'd0);

    // Bad npc: counted once per accept, saturating at 255.
    step(); drive(1, 16'h0020, 16'h0022, 1'b1); push_exp(1, 16'h2020, 16'h0022);
    step(); rd[1] = 1'b0;
    chk("npc_bad_perr", 32'(perr[1]), 32'(Chk));
    chk("npc_bad_ecnt1", 32'(ecnt[1]), Chk ? 32'd1 : 32'd0);
    step();
    for (int i = 0; i < 299; i++) begin
      step(); rd[1] = 1'b1; push_exp(1, 16'h2020, 16'h0022);
      step(); rd[1] = 1'b0;
    end
    step();
    step();
    chk("npc_bad_ecnt_sat", 32'(ecnt[1]), Chk ? 32'd255 : 32'd0);
    chk("ws0_no_err", 32'(ecnt[0]), 32'd0);

    // Reset while busy aborts the fetch; the array keeps its contents.
    step(); drive(2, 16'h0010, 16'h0011, 1'b1);
    step(); rd[2] = 1'b0;
    chk("abort_busy_before", 32'(busy[2]), 32'h1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy[2]), 32'h0);
    chk("abort_valid", 32'(valid[2]), 32'h0);
    chk("abort_dout", 32'(dout[2]), 32'h0);
    chk("abort_npc", 32'(npco[2]), 32'h0);
    chk("abort_ecnt", 32'(ecnt[2]), 32'h0);
    @(negedge clk) reset = 1'b1;
    valid_n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      valid_n += int'(valid[2]);
    end
    chk("abort_no_resp", 32'(valid_n), 32'd0);
    step(); drive(2, 16'h0010, 16'h0011, 1'b1); push_exp(2, 16'h1234, 16'h0011);
    step(); rd[2] = 1'b0;
    for (int i = 0; i < 5; i++) step();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
